// File: rtl/ddr_cmd_pkg.sv
// Shared opcodes, command-word field offsets, per-slot flag layout and FSM state
// type for the DDR command sequencer.
package ddr_cmd_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ACT  = 4'd1;
   localparam logic [3:0] OP_RD   = 4'd2;
   localparam logic [3:0] OP_WR   = 4'd3;
   localparam logic [3:0] OP_PRE  = 4'd4;
   localparam logic [3:0] OP_PREA = 4'd5;
   localparam logic [3:0] OP_REF  = 4'd6;
   localparam logic [3:0] OP_ZQ   = 4'd7;

   localparam int OP_LSB      = 0;
   localparam int AP_BIT      = 4;
   localparam int HALF_BL_BIT = 5;
   localparam int PACK_BIT    = 6;
   localparam int SLOT_LSB    = 8;
   localparam int BG_LSB      = 16;
   localparam int BANK_LSB    = 20;
   localparam int COL_LSB     = 24;
   localparam int ROW_LSB     = 40;
   localparam int WAIT_LSB    = 72;

   // Bit positions inside one slot's 10-bit flag vector.
   localparam int F_WRITE   = 0;
   localparam int F_READ    = 1;
   localparam int F_PRE     = 2;
   localparam int F_ACT     = 3;
   localparam int F_REF     = 4;
   localparam int F_ZQ      = 5;
   localparam int F_NOP     = 6;
   localparam int F_AP      = 7;
   localparam int F_PALL    = 8;
   localparam int F_HALF_BL = 9;

   // An idle slot: only nop set; the full NOP bundle is this in every slot with zero addresses.
   localparam logic [9:0] SLOT_NOP = 10'b00_0100_0000;

   typedef enum logic {IDLE, WAIT} state_t;

endpackage

// File: rtl/ddr_cmd_slot_decode.sv
// Combinational decode of one command word into a single slot's flags, address
// fields, target slot index and legality.
module ddr_cmd_slot_decode
   import ddr_cmd_pkg::*;
#(
   parameter int NUM_SLOTS  = 4,
   parameter int BG_WIDTH   = 2,
   parameter int BANK_WIDTH = 2,
   parameter int COL_WIDTH  = 10,
   parameter int ROW_WIDTH  = 17
)(
   input  logic [127:0]          cmd,
   output logic [9:0]            flags,
   output logic [BG_WIDTH-1:0]   bg,
   output logic [BANK_WIDTH-1:0] bank,
   output logic [COL_WIDTH-1:0]  col,
   output logic [ROW_WIDTH-1:0]  row,
   output logic [3:0]            slot,
   output logic                  legal,
   output logic                  emit
);

   logic [3:0] op;
   logic       unused_cmd;

   assign op   = cmd[OP_LSB +: 4];
   assign slot = cmd[SLOT_LSB +: 4];
   assign bg   = cmd[BG_LSB +: BG_WIDTH];
   assign bank = cmd[BANK_LSB +: BANK_WIDTH];
   assign col  = cmd[COL_LSB +: COL_WIDTH];
   assign row  = cmd[ROW_LSB +: ROW_WIDTH];

   assign legal = (op <= OP_ZQ) && ({1'b0, slot} < 5'(NUM_SLOTS));
   assign emit  = legal && (op != OP_NOP);

   assign unused_cmd = ^cmd;

   // ap and half_bl only carry meaning for column commands.
   always_comb begin
      flags = '0;
      case (op)
         OP_NOP:  flags[F_NOP] = 1'b1;
         OP_ACT:  flags[F_ACT] = 1'b1;
         OP_RD: begin
            flags[F_READ]    = 1'b1;
            flags[F_AP]      = cmd[AP_BIT];
            flags[F_HALF_BL] = cmd[HALF_BL_BIT];
         end
         OP_WR: begin
            flags[F_WRITE]   = 1'b1;
            flags[F_AP]      = cmd[AP_BIT];
            flags[F_HALF_BL] = cmd[HALF_BL_BIT];
         end
         OP_PRE:  flags[F_PRE] = 1'b1;
         OP_PREA: begin
            flags[F_PRE]  = 1'b1;
            flags[F_PALL] = 1'b1;
         end
         OP_REF:  flags[F_REF] = 1'b1;
         OP_ZQ:   flags[F_ZQ]  = 1'b1;
         default: flags = SLOT_NOP;
      endcase
   end

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Streams 128-bit command words into a registered multi-slot DFI command bundle with
// programmable NOP waits. Optional slot packing is enabled by DDR_CMD_SLOT_PACK_EN.
module ddr_cmd_sequencer
   import ddr_cmd_pkg::*;
#(
   parameter int NUM_SLOTS  = 4,
   parameter int BG_WIDTH   = 2,
   parameter int BANK_WIDTH = 2,
   parameter int COL_WIDTH  = 10,
   parameter int ROW_WIDTH  = 17,
   parameter int WAIT_WIDTH = 16
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic [127:0]                    S_AXIS_CMD_tdata,
   input  logic                            S_AXIS_CMD_tvalid,
   output logic                            S_AXIS_CMD_tready,
   output logic [NUM_SLOTS-1:0]            ddr_write,
   output logic [NUM_SLOTS-1:0]            ddr_read,
   output logic [NUM_SLOTS-1:0]            ddr_pre,
   output logic [NUM_SLOTS-1:0]            ddr_act,
   output logic [NUM_SLOTS-1:0]            ddr_ref,
   output logic [NUM_SLOTS-1:0]            ddr_zq,
   output logic [NUM_SLOTS-1:0]            ddr_nop,
   output logic [NUM_SLOTS-1:0]            ddr_ap,
   output logic [NUM_SLOTS-1:0]            ddr_pall,
   output logic [NUM_SLOTS-1:0]            ddr_half_bl,
   output logic [NUM_SLOTS*BG_WIDTH-1:0]   ddr_bg,
   output logic [NUM_SLOTS*BANK_WIDTH-1:0] ddr_bank,
   output logic [NUM_SLOTS*COL_WIDTH-1:0]  ddr_col,
   output logic [NUM_SLOTS*ROW_WIDTH-1:0]  ddr_row,
   output logic                            busy,
   output logic                            err,
   output logic [31:0]                     issued_count
);

   localparam int BGW = NUM_SLOTS*BG_WIDTH;
   localparam int BKW = NUM_SLOTS*BANK_WIDTH;
   localparam int CLW = NUM_SLOTS*COL_WIDTH;
   localparam int RWW = NUM_SLOTS*ROW_WIDTH;

   state_t                state_q, state_d;
   logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic [31:0]           issued_q, issued_d;

   logic [9:0]     flags_q [NUM_SLOTS];
   logic [BGW-1:0] bg_q;
   logic [BKW-1:0] bank_q;
   logic [CLW-1:0] col_q;
   logic [RWW-1:0] row_q;

   logic [9:0]     base_flags [NUM_SLOTS];
   logic [BGW-1:0] base_bg;
   logic [BKW-1:0] base_bank;
   logic [CLW-1:0] base_col;
   logic [RWW-1:0] base_row;

   logic [9:0]     merged_flags [NUM_SLOTS];
   logic [BGW-1:0] merged_bg;
   logic [BKW-1:0] merged_bank;
   logic [CLW-1:0] merged_col;
   logic [RWW-1:0] merged_row;

   logic [9:0]     next_flags [NUM_SLOTS];
   logic [BGW-1:0] next_bg;
   logic [BKW-1:0] next_bank;
   logic [CLW-1:0] next_col;
   logic [RWW-1:0] next_row;

   logic [9:0]            dec_flags;
   logic [BG_WIDTH-1:0]   dec_bg;
   logic [BANK_WIDTH-1:0] dec_bank;
   logic [COL_WIDTH-1:0]  dec_col;
   logic [ROW_WIDTH-1:0]  dec_row;
   logic [3:0]            dec_slot;
   logic                  dec_legal, dec_emit;

   logic                  accept, close, pack_bit, collide;
   logic [WAIT_WIDTH-1:0] wait_val;
   logic [31:0]           add;

`ifdef DDR_CMD_SLOT_PACK_EN
   logic [9:0]     acc_flags_q [NUM_SLOTS];
   logic [9:0]     acc_flags_d [NUM_SLOTS];
   logic [BGW-1:0] acc_bg_q, acc_bg_d;
   logic [BKW-1:0] acc_bank_q, acc_bank_d;
   logic [CLW-1:0] acc_col_q, acc_col_d;
   logic [RWW-1:0] acc_row_q, acc_row_d;
   logic           acc_open;

   assign pack_bit = S_AXIS_CMD_tdata[PACK_BIT];

   always_comb begin
      acc_open = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++)
         if (!acc_flags_q[s][F_NOP]) acc_open = 1'b1;
   end

   assign busy = (state_q != IDLE) || acc_open;
`else
   assign pack_bit = 1'b0;
   assign busy     = (state_q != IDLE);
`endif

   ddr_cmd_slot_decode #(
      .NUM_SLOTS (NUM_SLOTS),
      .BG_WIDTH  (BG_WIDTH),
      .BANK_WIDTH(BANK_WIDTH),
      .COL_WIDTH (COL_WIDTH),
      .ROW_WIDTH (ROW_WIDTH)
   ) u_decode (
      .cmd  (S_AXIS_CMD_tdata),
      .flags(dec_flags),
      .bg   (dec_bg),
      .bank (dec_bank),
      .col  (dec_col),
      .row  (dec_row),
      .slot (dec_slot),
      .legal(dec_legal),
      .emit (dec_emit)
   );

   assign S_AXIS_CMD_tready = (state_q == IDLE) && en;
   assign accept            = S_AXIS_CMD_tready && S_AXIS_CMD_tvalid;
   assign close             = accept && !pack_bit;
   assign wait_val          = S_AXIS_CMD_tdata[WAIT_LSB +: WAIT_WIDTH];

   // Merge the accepted command into the open bundle (the NOP bundle when not packing);
   // a closing command publishes the merge and starts its wait.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      collide  = 1'b0;
      add      = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
`ifdef DDR_CMD_SLOT_PACK_EN
         base_flags[s] = acc_flags_q[s];
`else
         base_flags[s] = SLOT_NOP;
`endif
         next_flags[s] = SLOT_NOP;
      end
`ifdef DDR_CMD_SLOT_PACK_EN
      base_bg   = acc_bg_q;
      base_bank = acc_bank_q;
      base_col  = acc_col_q;
      base_row  = acc_row_q;
`else
      base_bg   = '0;
      base_bank = '0;
      base_col  = '0;
      base_row  = '0;
`endif
      merged_flags = base_flags;
      merged_bg    = base_bg;
      merged_bank  = base_bank;
      merged_col   = base_col;
      merged_row   = base_row;
      next_bg      = '0;
      next_bank    = '0;
      next_col     = '0;
      next_row     = '0;

      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (accept && dec_emit && (4'(s) == dec_slot)) begin
            if (!base_flags[s][F_NOP]) begin
               collide = 1'b1;
            end else begin
               merged_flags[s]                             = dec_flags;
               merged_bg[s*BG_WIDTH +: BG_WIDTH]       = dec_bg;
               merged_bank[s*BANK_WIDTH +: BANK_WIDTH] = dec_bank;
               merged_col[s*COL_WIDTH +: COL_WIDTH]    = dec_col;
               merged_row[s*ROW_WIDTH +: ROW_WIDTH]    = dec_row;
            end
         end
      end

      if (accept && (!dec_legal || collide)) err_d = 1'b1;

      if (close) begin
         next_flags = merged_flags;
         next_bg    = merged_bg;
         next_bank  = merged_bank;
         next_col   = merged_col;
         next_row   = merged_row;
         if (wait_val != '0) begin
            state_d = WAIT;
            cnt_d   = wait_val;
         end
      end

      if (state_q == WAIT) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q <= WAIT_WIDTH'(1)) state_d = IDLE;
      end

      for (int s = 0; s < NUM_SLOTS; s++)
         if (!next_flags[s][F_NOP]) add = add + 32'd1;
      issued_d = issued_q + add;

`ifdef DDR_CMD_SLOT_PACK_EN
      acc_flags_d = acc_flags_q;
      acc_bg_d    = acc_bg_q;
      acc_bank_d  = acc_bank_q;
      acc_col_d   = acc_col_q;
      acc_row_d   = acc_row_q;
      if (accept) begin
         if (pack_bit) begin
            acc_flags_d = merged_flags;
            acc_bg_d    = merged_bg;
            acc_bank_d  = merged_bank;
            acc_col_d   = merged_col;
            acc_row_d   = merged_row;
         end else begin
            for (int s = 0; s < NUM_SLOTS; s++) acc_flags_d[s] = SLOT_NOP;
            acc_bg_d   = '0;
            acc_bank_d = '0;
            acc_col_d  = '0;
            acc_row_d  = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         issued_q <= '0;
         for (int s = 0; s < NUM_SLOTS; s++) flags_q[s] <= SLOT_NOP;
         bg_q     <= '0;
         bank_q   <= '0;
         col_q    <= '0;
         row_q    <= '0;
`ifdef DDR_CMD_SLOT_PACK_EN
         for (int s = 0; s < NUM_SLOTS; s++) acc_flags_q[s] <= SLOT_NOP;
         acc_bg_q   <= '0;
         acc_bank_q <= '0;
         acc_col_q  <= '0;
         acc_row_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         issued_q <= issued_d;
         for (int s = 0; s < NUM_SLOTS; s++) flags_q[s] <= next_flags[s];
         bg_q     <= next_bg;
         bank_q   <= next_bank;
         col_q    <= next_col;
         row_q    <= next_row;
`ifdef DDR_CMD_SLOT_PACK_EN
         for (int s = 0; s < NUM_SLOTS; s++) acc_flags_q[s] <= acc_flags_d[s];
         acc_bg_q   <= acc_bg_d;
         acc_bank_q <= acc_bank_d;
         acc_col_q  <= acc_col_d;
         acc_row_q  <= acc_row_d;
`endif
      end
   end

   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      assign ddr_write[s]   = flags_q[s][F_WRITE];
      assign ddr_read[s]    = flags_q[s][F_READ];
      assign ddr_pre[s]     = flags_q[s][F_PRE];
      assign ddr_act[s]     = flags_q[s][F_ACT];
      assign ddr_ref[s]     = flags_q[s][F_REF];
      assign ddr_zq[s]      = flags_q[s][F_ZQ];
      assign ddr_nop[s]     = flags_q[s][F_NOP];
      assign ddr_ap[s]      = flags_q[s][F_AP];
      assign ddr_pall[s]    = flags_q[s][F_PALL];
      assign ddr_half_bl[s] = flags_q[s][F_HALF_BL];
   end

   assign ddr_bg       = bg_q;
   assign ddr_bank     = bank_q;
   assign ddr_col      = col_q;
   assign ddr_row      = row_q;
   assign err          = err_q;
   assign issued_count = issued_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Table-driven, scoreboard-checked bench for ddr_cmd_sequencer with the default
// 4-slot geometry; the slot-pack sequence runs only when DDR_CMD_SLOT_PACK_EN is defined.
module tb_ddr_cmd_sequencer;

   typedef struct {
      logic [3:0]  op;
      logic        ap;
      logic        hbl;
      logic [3:0]  slot;
      logic [3:0]  bg;
      logic [3:0]  bank;
      logic [15:0] col;
      logic [31:0] row;
      logic [15:0] wt;
      logic [3:0]  e_write, e_read, e_pre, e_act, e_ref, e_zq, e_ap, e_pall, e_hbl;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic [39:0] flags;
      logic [7:0]  bg;
      logic [7:0]  bank;
      logic [39:0] col;
      logic [67:0] row;
      logic        err;
      logic [31:0] issued;
      logic        busy;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, en, tvalid;
   logic [127:0] tdata;
   logic         tready;
   logic [3:0]   ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq;
   logic [3:0]   ddr_nop, ddr_ap, ddr_pall, ddr_half_bl;
   logic [7:0]   ddr_bg, ddr_bank;
   logic [39:0]  ddr_col;
   logic [67:0]  ddr_row;
   logic         busy, err;
   logic [31:0]  issued_count;

   exp_t        sb[$];
   vec_t        vecs[13];
   int          n_vectors = 0;
   int          n_miscompares = 0;
   logic        exp_err = 1'b0;
   logic [31:0] exp_issued = '0;

   always #5 clk = ~clk;

   ddr_cmd_sequencer dut (
      .clk(clk), .rst(rst), .en(en),
      .S_AXIS_CMD_tdata(tdata), .S_AXIS_CMD_tvalid(tvalid), .S_AXIS_CMD_tready(tready),
      .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre), .ddr_act(ddr_act),
      .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_nop(ddr_nop), .ddr_ap(ddr_ap),
      .ddr_pall(ddr_pall), .ddr_half_bl(ddr_half_bl),
      .ddr_bg(ddr_bg), .ddr_bank(ddr_bank), .ddr_col(ddr_col), .ddr_row(ddr_row),
      .busy(busy), .err(err), .issued_count(issued_count)
   );

   function automatic logic [127:0] mkCmd(input logic [3:0] op, input logic ap, input logic hbl,
                                          input logic pack, input logic [3:0] slot,
                                          input logic [3:0] bg, input logic [3:0] bank,
                                          input logic [15:0] col, input logic [31:0] row,
                                          input logic [31:0] wt);
      logic [127:0] c;
      c          = '0;
      c[3:0]     = op;
      c[4]       = ap;
      c[5]       = hbl;
      c[6]       = pack;
      c[7]       = 1'b1;
      c[11:8]    = slot;
      c[15:12]   = 4'h9;
      c[19:16]   = bg;
      c[23:20]   = bank;
      c[39:24]   = col;
      c[71:40]   = row;
      c[103:72]  = wt;
      c[127:104] = 24'hA5C3E1;
      return c;
   endfunction

   function automatic logic [39:0] mkFlags(input logic [3:0] w, input logic [3:0] r,
                                           input logic [3:0] p, input logic [3:0] a,
                                           input logic [3:0] rf, input logic [3:0] z,
                                           input logic [3:0] ap, input logic [3:0] pall,
                                           input logic [3:0] hbl);
      logic [3:0] nop;
      nop = ~(w | r | p | a | rf | z);
      return {w, r, p, a, rf, z, nop, ap, pall, hbl};
   endfunction

   function automatic exp_t nopExp(input logic b);
      exp_t e;
      e.flags  = mkFlags(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      e.bg     = '0;
      e.bank   = '0;
      e.col    = '0;
      e.row    = '0;
      e.err    = exp_err;
      e.issued = exp_issued;
      e.busy   = b;
      return e;
   endfunction

   task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] req);
      n_vectors++;
      if (act !== req) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checkVal("scoreboard_empty", 128'd0, 128'd1);
         return;
      end
      e = sb.pop_front();
      checkVal("flags", 128'({ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq,
                              ddr_nop, ddr_ap, ddr_pall, ddr_half_bl}), 128'(e.flags));
      checkVal("bg", 128'(ddr_bg), 128'(e.bg));
      checkVal("bank", 128'(ddr_bank), 128'(e.bank));
      checkVal("col", 128'(ddr_col), 128'(e.col));
      checkVal("row", 128'(ddr_row), 128'(e.row));
      checkVal("err", 128'(err), 128'(e.err));
      checkVal("issued_count", 128'(issued_count), 128'(e.issued));
      checkVal("busy", 128'(busy), 128'(e.busy));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Drive one command, expect it in the following cycle, then expect min(wt, max_wait) NOP cycles.
   task automatic applyStimulus(input vec_t v, input int max_wait);
      exp_t e;
      int   n;
      tdata  = mkCmd(v.op, v.ap, v.hbl, 1'b0, v.slot, v.bg, v.bank, v.col, v.row, {16'h0, v.wt});
      tvalid = 1'b1;
      if (!tready) begin
         checkVal("tready_idle", 128'(tready), 128'd1);
         tvalid = 1'b0;
         return;
      end
      e.flags = mkFlags(v.e_write, v.e_read, v.e_pre, v.e_act, v.e_ref, v.e_zq,
                        v.e_ap, v.e_pall, v.e_hbl);
      e.bg = '0; e.bank = '0; e.col = '0; e.row = '0;
      n = 0;
      for (int s = 0; s < 4; s++) begin
         if (!e.flags[12 + s]) begin
            n++;
            e.bg[s*2 +: 2]    = v.bg[1:0];
            e.bank[s*2 +: 2]  = v.bank[1:0];
            e.col[s*10 +: 10] = v.col[9:0];
            e.row[s*17 +: 17] = v.row[16:0];
         end
      end
      exp_err    = exp_err | v.e_err;
      exp_issued = exp_issued + 32'(n);
      e.err      = exp_err;
      e.issued   = exp_issued;
      e.busy     = (v.wt != 16'd0);
      sb.push_back(e);
      tick();
      for (int i = 1; i <= int'(v.wt) && i <= max_wait; i++) begin
         checkVal("tready_wait", 128'(tready), 128'd0);
         sb.push_back(nopExp(i < int'(v.wt)));
         tick();
      end
      tvalid = 1'b0;
   endtask

`ifdef DDR_CMD_SLOT_PACK_EN
   task automatic sendPack(input logic [127:0] c, input exp_t e);
      tdata  = c;
      tvalid = 1'b1;
      if (!tready) begin
         checkVal("tready_pack", 128'(tready), 128'd1);
         tvalid = 1'b0;
         return;
      end
      sb.push_back(e);
      tick();
      tvalid = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t r;
`ifdef DDR_CMD_SLOT_PACK_EN
      exp_t e;
`endif
      //           op    ap    hbl   slot  bg    bank  col       row           wt      write  read   pre    act    ref    zq     ap     pall   hbl    err
      vecs[0]  = '{4'd1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd1, 16'h0000, 32'h00001234, 16'd0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[1]  = '{4'd2, 1'b1, 1'b1, 4'd0, 4'd1, 4'd2, 16'h0155, 32'h00000000, 16'd3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0};
      vecs[2]  = '{4'd3, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 16'h02AA, 32'h00000000, 16'd0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[3]  = '{4'd3, 1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 16'h0011, 32'h00000000, 16'd0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h8, 1'b0};
      vecs[4]  = '{4'd4, 1'b1, 1'b1, 4'd1, 4'd1, 4'd1, 16'h0000, 32'h00000000, 16'd0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[5]  = '{4'd5, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 32'h00000000, 16'd1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0};
      vecs[6]  = '{4'd6, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 16'h0000, 32'h00000000, 16'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[7]  = '{4'd7, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 16'h0000, 32'h00000000, 16'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[8]  = '{4'd1, 1'b0, 1'b0, 4'd3, 4'hF, 4'hF, 16'hFFFF, 32'hFFFFFFFF, 16'd0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[9]  = '{4'd0, 1'b0, 1'b0, 4'd2, 4'd1, 4'd1, 16'h0001, 32'h00000001, 16'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      vecs[10] = '{4'hA, 1'b0, 1'b0, 4'd0, 4'd1, 4'd1, 16'h0001, 32'h00000001, 16'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
      vecs[11] = '{4'd1, 1'b0, 1'b0, 4'd5, 4'd1, 4'd1, 16'h0001, 32'h00000001, 16'd2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
      vecs[12] = '{4'd2, 1'b0, 1'b0, 4'd2, 4'd2, 4'd1, 16'h0033, 32'h00000077, 16'd0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};

      rst = 1'b1; en = 1'b1; tvalid = 1'b0; tdata = '0;
      sb.push_back(nopExp(1'b0)); tick();
      sb.push_back(nopExp(1'b0)); tick();
      rst = 1'b0;

      for (int i = 0; i < 13; i++) applyStimulus(vecs[i], 1000);

      // Abort a long wait half-way through with reset.
      r = '{4'd4, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 16'h0000, 32'h00000000, 16'd100,
            4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      applyStimulus(r, 50);
      rst = 1'b1;
      exp_err = 1'b0;
      exp_issued = '0;
      sb.push_back(nopExp(1'b0)); tick();
      rst = 1'b0;
      #1;
      checkVal("tready_after_rst", 128'(tready), 128'd1);

      // With en low nothing is accepted even though tvalid is held.
      en = 1'b0;
      tdata = mkCmd(4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0, 32'h0, 32'h0);
      tvalid = 1'b1;
      #1;
      checkVal("tready_en_low", 128'(tready), 128'd0);
      for (int i = 0; i < 3; i++) begin
         sb.push_back(nopExp(1'b0)); tick();
      end
      tvalid = 1'b0;
      en = 1'b1;
      #1;

      r = '{4'd6, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 32'h00000000, 16'd0,
            4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
      for (int i = 0; i < 8; i++) applyStimulus(r, 1000);
      checkVal("issued_after_8_ref", 128'(issued_count), 128'd8);

`ifdef DDR_CMD_SLOT_PACK_EN
      sendPack(mkCmd(4'd1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 16'h0, 32'h55, 32'd9), nopExp(1'b1));
      sendPack(mkCmd(4'd4, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 16'h0, 32'h0, 32'd0), nopExp(1'b1));
      exp_err = 1'b1;
      sendPack(mkCmd(4'd7, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 16'h0, 32'h0, 32'd0), nopExp(1'b1));
      exp_issued = exp_issued + 32'd3;
      e = nopExp(1'b0);
      e.flags = mkFlags(4'h0, 4'h2, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      e.row[16:0] = 17'h55;
      sendPack(mkCmd(4'd2, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 16'h0, 32'h0, 32'd0), e);
      exp_issued = exp_issued + 32'd1;
      e = nopExp(1'b0);
      e.flags = mkFlags(4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      sendPack(mkCmd(4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0, 32'h0, 32'd0), e);
`endif

      sb.push_back(nopExp(1'b0)); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
